// File: rtl/led_seg_scan.sv
// Multiplexed 4-digit common-anode hex display driver with per-frame value capture.
// Optional leading-zero blanking is enabled by defining LED_SEG_LZB_EN.
module led_seg_scan #(
    parameter int DIV_CNT = 50000,
    parameter int GAP_CNT = 16,
    parameter int CNT_W   = 17
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] led_in,
    input  logic        disp_en,
    output logic [7:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CNT > 0) ? GAP_CNT - 1 : 0);

    state_t           state, nxt_state;
    logic [1:0]       digit, nxt_digit;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [15:0]      shadow, nxt_shadow;
    logic             chg, nxt_chg;
    logic             advance;
    logic             nxt_frame_done;
    logic [7:0]       nxt_seg_n;
    logic [3:0]       nxt_an_n;
    logic [3:0]       nib;
    logic             lzb_blank;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] code;
        case (n)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            digit      <= 2'd0;
            cnt        <= '0;
            shadow     <= 16'h0;
            chg        <= 1'b0;
            seg_n      <= 8'hFF;
            an_n       <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            digit      <= nxt_digit;
            cnt        <= nxt_cnt;
            shadow     <= nxt_shadow;
            chg        <= nxt_chg;
            seg_n      <= nxt_seg_n;
            an_n       <= nxt_an_n;
            frame_done <= nxt_frame_done;
        end
    end

    always_comb begin
        nxt_state      = state;
        nxt_digit      = digit;
        nxt_cnt        = cnt;
        nxt_shadow     = shadow;
        nxt_chg        = chg;
        nxt_frame_done = 1'b0;
        advance        = 1'b0;

        if (!disp_en) begin
            nxt_state = IDLE;
            nxt_digit = 2'd0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_shadow = led_in;
                    nxt_chg    = 1'b0;
                    nxt_digit  = 2'd0;
                    nxt_cnt    = '0;
                    nxt_state  = SHOW;
                end
                SHOW: begin
                    if (cnt == DIV_LAST) begin
                        nxt_cnt = '0;
                        if (GAP_CNT == 0) advance = 1'b1;
                        else nxt_state = GAP;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        nxt_cnt = '0;
                        advance = 1'b1;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_digit = 2'd0;
                    nxt_cnt   = '0;
                end
            endcase

            // Frame boundary is the only point where a new value is captured
            if (advance) begin
                nxt_state = SHOW;
                if (digit != 2'd3) begin
                    nxt_digit = digit + 2'd1;
                end else begin
                    nxt_digit      = 2'd0;
                    nxt_shadow     = led_in;
                    nxt_chg        = (led_in != shadow);
                    nxt_frame_done = 1'b1;
                end
            end
        end

        nib = nxt_shadow[{nxt_digit, 2'b00} +: 4];
`ifdef LED_SEG_LZB_EN
        lzb_blank = (nxt_digit != 2'd0) && ((nxt_shadow >> {nxt_digit, 2'b00}) == 16'h0);
`else
        lzb_blank = 1'b0;
`endif

        nxt_seg_n = 8'hFF;
        nxt_an_n  = 4'hF;
        if (nxt_state == SHOW) begin
            nxt_an_n = ~(4'b0001 << nxt_digit);
            if (!lzb_blank) begin
                nxt_seg_n = {~((nxt_digit == 2'd0) && nxt_chg), hex7(nib)};
            end
        end
    end

endmodule
